// File: rtl/axis_zero_byte_compressor.sv
// rtl/axis_zero_byte_compressor.sv - AXI-Stream zero-byte compressor with per-packet bypass
//
// Each accepted beat becomes a token: a DATA_BYTES-bit nonzero-byte mask (MB bytes),
// followed by only the nonzero bytes. Tokens are packed densely into full output beats.
// Packet boundaries are preserved. A packet whose first beat has bypass_in=1 passes
// through unchanged, registered, with one cycle of latency.
//
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   data_in/tkeep_in/tlast_in   upstream beat; tkeep contiguous from byte 0
//   tvalid_in/tready_out        upstream handshake
//   bypass_in                   sampled on the first beat of each packet
//   data_out/tkeep_out/tlast_out downstream beat, little-endian packed
//   tvalid_out/tready_in        downstream handshake
module axis_zero_byte_compressor #(
  parameter int DATA_BYTES = 32,
  parameter int BUF_BYTES  = 2*DATA_BYTES + DATA_BYTES/8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*DATA_BYTES-1:0] data_in,
  input  logic                    tvalid_in,
  input  logic                    tlast_in,
  input  logic [DATA_BYTES-1:0]   tkeep_in,
  input  logic                    bypass_in,
  output logic                    tready_out,
  output logic [8*DATA_BYTES-1:0] data_out,
  output logic                    tvalid_out,
  output logic                    tlast_out,
  output logic [DATA_BYTES-1:0]   tkeep_out,
  input  logic                    tready_in
);
  localparam int MB        = DATA_BYTES/8;
  localparam int TOK_BYTES = MB + DATA_BYTES;
  localparam int TW        = $clog2(TOK_BYTES+1);
  localparam int FW        = $clog2(BUF_BYTES+1);
  localparam logic [FW-1:0] DB_F      = FW'(DATA_BYTES);
  localparam logic [FW-1:0] READY_MAX = FW'(BUF_BYTES - TOK_BYTES);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                     state_q, state_n;
  logic                       mode_q;
  logic                       ready_en_q;
  logic [BUF_BYTES-1:0][7:0]  rbuf_q, rbuf_n, shifted, tok_ext;
  logic [FW-1:0]              fill_q, fill_n, pop_cnt, occ_after, wr_pos;
  logic [TOK_BYTES-1:0][7:0]  tok, tok_q;
  logic [TW-1:0]              tok_len, tok_len_q;
  logic                       tok_valid_q;
  logic [DATA_BYTES-1:0]      mask, load_keep;
  logic                       mode_eff, out_free, acc, acc_byp, acc_cmp, load_cmp, cmp_last;

  // Token builder: mask bytes first, then nonzero kept bytes compacted in ascending order.
  always_comb begin
    mask    = '0;
    tok     = '0;
    tok_len = TW'(MB);
    for (int i = 0; i < DATA_BYTES; i++)
      mask[i] = tkeep_in[i] && (data_in[8*i +: 8] != 8'h00);
    tok[MB-1:0] = mask;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (mask[i]) begin
        tok[tok_len] = data_in[8*i +: 8];
        tok_len      = tok_len + 1'b1;
      end
    end
  end

  // The first beat of a packet decides the mode; afterwards the latched mode rules.
  assign mode_eff = (state_q == IDLE) ? bypass_in : mode_q;
  assign out_free = !tvalid_out || tready_in;

  // A remainder beat is only emitted once the packet's last token has landed in the buffer.
  assign load_cmp = out_free &&
                    ((fill_q >= DB_F) || (state_q == FLUSH && !tok_valid_q && fill_q != '0));
  assign cmp_last = (state_q == FLUSH) && !tok_valid_q && (fill_q <= DB_F);
  assign pop_cnt  = !load_cmp ? '0 : ((fill_q >= DB_F) ? DB_F : fill_q);
  assign load_keep = (fill_q >= DB_F) ? '1 : ((DATA_BYTES'(1) << fill_q) - DATA_BYTES'(1));

  // Occupancy after this edge, including the staged token; a worst-case token accepted now
  // is appended one edge later, so it must fit on top of this.
  assign occ_after  = fill_q + (tok_valid_q ? FW'(tok_len_q) : '0) - pop_cnt;
  assign tready_out = ready_en_q &&
                      (mode_eff ? out_free : (state_q != FLUSH && occ_after <= READY_MAX));
  assign acc     = tvalid_in && tready_out;
  assign acc_byp = acc && mode_eff;
  assign acc_cmp = acc && !mode_eff;

  // Bytes at and above fill are always zero, so append is a shifted OR.
  always_comb begin
    wr_pos  = fill_q - pop_cnt;
    shifted = load_cmp ? (rbuf_q >> (8*DATA_BYTES)) : rbuf_q;
    tok_ext = '0;
    tok_ext[TOK_BYTES-1:0] = tok_q;
    rbuf_n  = shifted;
    if (tok_valid_q)
      rbuf_n = shifted | (tok_ext << {wr_pos, 3'b000});
    fill_n  = occ_after;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:  if (acc) state_n = tlast_in ? (bypass_in ? IDLE : FLUSH) : RUN;
      RUN:   if (acc && tlast_in) state_n = mode_q ? IDLE : FLUSH;
      // The beat taken may be a leftover bypass beat, so also require an empty buffer.
      FLUSH: if (tvalid_out && tready_in && tlast_out && fill_q == '0 && !tok_valid_q)
               state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= 1'b0;
      ready_en_q  <= 1'b0;
      rbuf_q      <= '0;
      fill_q      <= '0;
      tok_q       <= '0;
      tok_len_q   <= '0;
      tok_valid_q <= 1'b0;
      tvalid_out  <= 1'b0;
      tlast_out   <= 1'b0;
      tkeep_out   <= '0;
      data_out    <= '0;
    end else begin
      ready_en_q  <= 1'b1;
      if (acc && state_q == IDLE) mode_q <= bypass_in;
      tok_valid_q <= acc_cmp;
      if (acc_cmp) begin
        tok_q     <= tok;
        tok_len_q <= tok_len;
      end
      rbuf_q <= rbuf_n;
      fill_q <= fill_n;
      if (acc_byp) begin
        data_out   <= data_in;
        tkeep_out  <= tkeep_in;
        tlast_out  <= tlast_in;
        tvalid_out <= 1'b1;
      end else if (load_cmp) begin
        data_out   <= rbuf_q[DATA_BYTES-1:0];
        tkeep_out  <= load_keep;
        tlast_out  <= cmp_last;
        tvalid_out <= 1'b1;
      end else if (tready_in) begin
        tvalid_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axis_zero_byte_compressor.sv
// tb/tb_axis_zero_byte_compressor.sv - randomized self-checking bench for axis_zero_byte_compressor
module tb_axis_zero_byte_compressor;
  localparam int DB = 32;
  localparam int MB = DB/8;

  logic          clk = 1'b0;
  logic          reset;
  logic [8*DB-1:0] data_in, data_out;
  logic          tvalid_in, tlast_in, bypass_in, tready_out, tvalid_out, tlast_out, tready_in;
  logic [DB-1:0] tkeep_in, tkeep_out;

  axis_zero_byte_compressor #(.DATA_BYTES(DB)) dut (
    .clk(clk), .reset(reset),
    .data_in(data_in), .tvalid_in(tvalid_in), .tlast_in(tlast_in), .tkeep_in(tkeep_in),
    .bypass_in(bypass_in), .tready_out(tready_out),
    .data_out(data_out), .tvalid_out(tvalid_out), .tlast_out(tlast_out),
    .tkeep_out(tkeep_out), .tready_in(tready_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8*DB-1:0] exp_d[$];
  logic [DB-1:0]   exp_k[$];
  logic            exp_l[$];
  logic [8*DB-1:0] got_d[$];
  logic [DB-1:0]   got_k[$];
  logic            got_l[$];
  logic [8*DB-1:0] pd[8];
  logic [DB-1:0]   pk[8];
  int rdy_mode = 2;
  bit saw_drop = 0;

  task automatic check(input string tag, input logic [8*DB-1:0] got, input logic [8*DB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor and scoreboard, sampled on the falling edge.
  logic [8*DB-1:0] hold_d;
  logic [DB-1:0]   hold_k;
  logic            hold_l;
  bit              holding = 0;
  always @(negedge clk) begin
    if (reset) begin
      holding = 0;
    end else begin
      if (holding) begin
        check("stall_valid", tvalid_out, 1);
        check("stall_data", data_out, hold_d);
        check("stall_keep", tkeep_out, hold_k);
        check("stall_last", tlast_out, hold_l);
      end
      holding = tvalid_out && !tready_in;
      hold_d = data_out; hold_k = tkeep_out; hold_l = tlast_out;
      if (rdy_mode == 1 && tvalid_in && !tready_out) saw_drop = 1;
      if (tvalid_out && tready_in) begin
        got_d.push_back(data_out); got_k.push_back(tkeep_out); got_l.push_back(tlast_out);
        if (exp_d.size() == 0) check("beat_expected", exp_d.size(), 1);
        else begin
          check("beat_data", data_out, exp_d.pop_front());
          check("beat_keep", tkeep_out, exp_k.pop_front());
          check("beat_last", tlast_out, exp_l.pop_front());
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: tready_in = 1'($urandom_range(0, 1));
      1: tready_in = !tready_in;
      default: tready_in = 1'b1;
    endcase
  end

  // Reference: byte stream of tokens cut into DB-byte beats; bypass copies beats.
  task automatic model_packet(input int nb, input bit byp);
    logic [7:0]      bq[$];
    logic [7:0]      nz[$];
    logic [DB-1:0]   m;
    logic [8*DB-1:0] d;
    logic [DB-1:0]   k;
    int n;
    for (int b = 0; b < nb; b++) begin
      if (byp) begin
        exp_d.push_back(pd[b]); exp_k.push_back(pk[b]); exp_l.push_back(b == nb-1);
      end else begin
        m = '0; nz.delete();
        for (int i = 0; i < DB; i++)
          if (pk[b][i] && pd[b][8*i +: 8] != 8'h00) begin m[i] = 1'b1; nz.push_back(pd[b][8*i +: 8]); end
        for (int j = 0; j < MB; j++) bq.push_back(m[8*j +: 8]);
        foreach (nz[i]) bq.push_back(nz[i]);
      end
    end
    while (bq.size() > 0) begin
      n = (bq.size() > DB) ? DB : bq.size();
      d = '0; k = '0;
      for (int i = 0; i < n; i++) begin d[8*i +: 8] = bq.pop_front(); k[i] = 1'b1; end
      exp_d.push_back(d); exp_k.push_back(k); exp_l.push_back(bq.size() == 0);
    end
  endtask

  task automatic send_beat(input logic [8*DB-1:0] d, input logic [DB-1:0] k, input logic l, input logic b);
    int budget = 3000;
    data_in = d; tkeep_in = k; tlast_in = l; bypass_in = b; tvalid_in = 1'b1;
    @(negedge clk);
    while (!tready_out && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) check("accept_timeout", tready_out, 1);
    @(posedge clk); #1;
    tvalid_in = 1'b0;
  endtask

  task automatic run_packet(input int nb, input bit byp, input bit gaps);
    model_packet(nb, byp);
    for (int b = 0; b < nb; b++) begin
      send_beat(pd[b], pk[b], b == nb-1, (b == 0) ? byp : 1'($urandom_range(0, 1)));
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic gen_packet(input int nb, input bit all_ff);
    int n;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < DB; i++)
        pd[b][8*i +: 8] = all_ff ? 8'hFF : (($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00);
      pk[b] = '1;
    end
    n = $urandom_range(1, DB);
    for (int i = 0; i < DB; i++) pk[nb-1][i] = (i < n);
  endtask

  task automatic drain();
    int budget = 5000;
    while ((exp_d.size() != 0 || tvalid_out) && budget > 0) begin @(negedge clk); budget--; end
    check("drain_left", exp_d.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_beat(input string tag, input int idx, input int nbits,
                            input logic [8*DB-1:0] d, input logic [DB-1:0] k, input logic l);
    logic [8*DB-1:0] msk;
    msk = (nbits >= 8*DB) ? '1 : (((8*DB)'(1) << nbits) - (8*DB)'(1));
    if (got_d.size() <= idx) check({tag, "_present"}, got_d.size(), idx+1);
    else begin
      check({tag, "_data"}, got_d[idx] & msk, d);
      check({tag, "_keep"}, got_k[idx], k);
      check({tag, "_last"}, got_l[idx], l);
    end
  endtask

  task automatic case2_packet();
    pd[0] = '0; pd[0][7:0] = 8'h11; pd[0][47:40] = 8'h22; pk[0] = '1;
    run_packet(1, 0, 0);
    drain();
  endtask

  initial begin
    int base;
    reset = 1'b1; tvalid_in = 0; tlast_in = 0; tkeep_in = '0; data_in = '0; bypass_in = 0; tready_in = 1;
    repeat (3) @(posedge clk); #1;
    check("rst_tvalid", tvalid_out, 0);
    check("rst_tlast", tlast_out, 0);
    check("rst_tkeep", tkeep_out, 0);
    check("rst_data", data_out, 0);
    check("rst_tready", tready_out, 0);
    reset = 1'b0; #1;
    check("tready_before_clk", tready_out, 0);
    @(posedge clk); #1;
    check("tready_after_clk", tready_out, 1);

    // single all-zero beat
    base = got_d.size();
    pd[0] = '0; pk[0] = '1; run_packet(1, 0, 0); drain();
    check_beat("zero_beat", base, 32, 256'h0, 32'h0000000F, 1'b1);

    // two nonzero bytes
    base = got_d.size();
    case2_packet();
    check_beat("two_bytes", base, 48, 256'h2211_0000_0021, 32'h0000003F, 1'b1);

    // four all-FF beats, exact multiple of the output width
    base = got_d.size();
    for (int b = 0; b < 4; b++) begin pd[b] = '1; pk[b] = '1; end
    pk[3] = 32'h0000FFFF;
    run_packet(4, 0, 0); drain();
    check("ff_beat_count", got_d.size() - base, 4);
    check_beat("ff_first", base, 32, 256'hFFFFFFFF, '1, 1'b0);
    check_beat("ff_last", base+3, 0, 256'h0, '1, 1'b1);

    // bypass packet with bypass_in toggled mid-packet, then a compressed packet
    gen_packet(3, 0);
    model_packet(3, 1);
    for (int b = 0; b < 3; b++) begin
      send_beat(pd[b], pk[b], b == 2, (b == 1) ? 1'b0 : 1'b1);
      check("byp_valid", tvalid_out, 1);
      check("byp_data", data_out, pd[b]);
      check("byp_keep", tkeep_out, pk[b]);
    end
    drain();
    gen_packet(2, 0);
    run_packet(2, 0, 0); drain();

    // randomized mix with random downstream backpressure
    rdy_mode = 0;
    for (int p = 0; p < 30; p++) begin
      int nb;
      nb = $urandom_range(1, 5);
      gen_packet(nb, 0);
      run_packet(nb, ($urandom_range(0, 3) == 0), 1);
    end
    drain();

    // saturating all-FF stream with alternating ready
    rdy_mode = 1; saw_drop = 0;
    for (int b = 0; b < 6; b++) begin pd[b] = '1; pk[b] = '1; end
    run_packet(6, 0, 0); drain();
    check("ready_dropped", saw_drop, 1);
    rdy_mode = 2;

    // reset mid-packet with 20 bytes buffered
    pd[0] = '0;
    for (int i = 0; i < 16; i++) pd[0][8*i +: 8] = 8'(i + 1);
    send_beat(pd[0], '1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1; #1;
    check("mid_rst_tvalid", tvalid_out, 0);
    check("mid_rst_tkeep", tkeep_out, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_tready", tready_out, 0);
    exp_d.delete(); exp_k.delete(); exp_l.delete();
    base = got_d.size();
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    case2_packet();
    check("post_rst_beats", got_d.size() - base, 1);
    check_beat("post_rst", base, 48, 256'h2211_0000_0021, 32'h0000003F, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
